regfile_write_arbiter: RTL and testbench

//  Sole owner of the register-file write port (din/writeEnable/rd).

---
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - write-back request bus and register-file write port
`timescale 1ns/1ps

interface regfile_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 init_busy;

    modport master (
        output hold, req_valid, req_rd, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, init_busy
    );

    modport slave (
        input  hold, req_valid, req_rd, req_data,
        output req_ready, wr_en, wr_addr, wr_data, init_busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - clears r0..rN after reset, then round-robins write-backs onto the regfile port
`timescale 1ns/1ps

module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     clr_cnt_q, clr_cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            init_busy_q, init_busy_d;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] ready;
    logic [AW-1:0]   gnt_rd;
    logic [DW-1:0]   gnt_data;

    // Scan from the farthest offset down so the offset closest to ptr wins.
    always_comb begin : arb_scan
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state_q == ST_RUN && !bus.hold && gnt_found) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_rd   = bus.req_rd[int'(gnt_idx) * AW +: AW];
        gnt_data = bus.req_data[int'(gnt_idx) * DW +: DW];
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        init_busy_d = init_busy_q;
        case (state_q)
            ST_CLEAR: begin
                // Top counter bit set means the last register has been zeroed.
                if (clr_cnt_q[AW]) begin
                    state_d     = ST_RUN;
                    init_busy_d = 1'b0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = clr_cnt_q[AW-1:0];
                    wr_data_d = '0;
                    clr_cnt_d = clr_cnt_q + (AW+1)'(1);
                end
            end
            ST_RUN: begin
                if (ready != '0) begin
                    wr_en_d   = (gnt_rd != '0);
                    wr_addr_d = gnt_rd;
                    wr_data_d = gnt_data;
                    ptr_d     = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.init_busy = init_busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector table plus clear, reset and randomised handshake sequences
`timescale 1ns/1ps

module tb_regfile_write_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0000;
    localparam logic [31:0] D2 = 32'h3333_0000;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [14:0] RD_A = {5'd3, 5'd2, 5'd1};
    localparam logic [14:0] RD_Z = {5'd3, 5'd2, 5'd0};
    localparam logic [14:0] RD_9 = {5'd9, 5'd9, 5'd1};
    localparam logic [95:0] DA   = {D2, D1, D0};
    localparam logic [95:0] DZ   = {D2, D1, DB};

    typedef struct {
        logic        hold;
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (bus.wr_en) rf[bus.wr_addr] <= bus.wr_data;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_clear(input logic [2:0] exp_ready_after);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            chk($sformatf("clr%0d_wr_en", i), bus.wr_en, 1);
            chk($sformatf("clr%0d_wr_addr", i), bus.wr_addr, i);
            chk($sformatf("clr%0d_wr_data", i), bus.wr_data, 0);
            chk($sformatf("clr%0d_busy", i), bus.init_busy, 1);
            chk($sformatf("clr%0d_ready", i), bus.req_ready, 0);
        end
        @(posedge clk); #1;
        chk("clr_done_wr_en", bus.wr_en, 0);
        chk("clr_done_busy", bus.init_busy, 0);
        chk("clr_done_ready", bus.req_ready, exp_ready_after);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [15];
        logic [2:0]  pend;
        logic [2:0]  acc;
        logic [2:0]  r;
        logic [14:0] rrd;
        logic [95:0] rdat;
        int          wt [3];
        logic        have_exp;
        logic        exp_en;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;

        vt[0]  = '{1'b0, 3'b111, RD_A, DA, 3'b001, 1'b1, 5'd1, D0};
        vt[1]  = '{1'b0, 3'b111, RD_A, DA, 3'b010, 1'b1, 5'd2, D1};
        vt[2]  = '{1'b0, 3'b111, RD_A, DA, 3'b100, 1'b1, 5'd3, D2};
        vt[3]  = '{1'b0, 3'b001, RD_Z, DZ, 3'b001, 1'b0, 5'd0, DB};
        vt[4]  = '{1'b0, 3'b000, RD_A, DA, 3'b000, 1'b0, 5'd0, DB};
        vt[5]  = '{1'b1, 3'b101, RD_A, DA, 3'b000, 1'b0, 5'd0, DB};
        vt[6]  = '{1'b1, 3'b101, RD_A, DA, 3'b000, 1'b0, 5'd0, DB};
        vt[7]  = '{1'b1, 3'b101, RD_A, DA, 3'b000, 1'b0, 5'd0, DB};
        vt[8]  = '{1'b1, 3'b101, RD_A, DA, 3'b000, 1'b0, 5'd0, DB};
        vt[9]  = '{1'b0, 3'b101, RD_A, DA, 3'b100, 1'b1, 5'd3, D2};
        vt[10] = '{1'b0, 3'b001, RD_A, DA, 3'b001, 1'b1, 5'd1, D0};
        vt[11] = '{1'b0, 3'b110, RD_9, DA, 3'b010, 1'b1, 5'd9, D1};
        vt[12] = '{1'b0, 3'b100, RD_9, DA, 3'b100, 1'b1, 5'd9, D2};
        vt[13] = '{1'b0, 3'b010, RD_A, DA, 3'b010, 1'b1, 5'd2, D1};
        vt[14] = '{1'b0, 3'b011, RD_A, DA, 3'b001, 1'b1, 5'd1, D0};

        bus.hold      = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_rd    = RD_A;
        bus.req_data  = DA;
        rst           = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_busy", bus.init_busy, 1);
        chk("rst_ready", bus.req_ready, 0);

        @(negedge clk);
        rst = 1'b1;
        run_clear(3'b001);
        chk("rf_r31_cleared", rf[31], 0);

        for (int i = 0; i < 15; i++) begin
            bus.hold      = vt[i].hold;
            bus.req_valid = vt[i].valid;
            bus.req_rd    = vt[i].rd;
            bus.req_data  = vt[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), bus.req_ready, vt[i].exp_ready);
            @(posedge clk); #1;
            chk($sformatf("v%0d_wr_en", i), bus.wr_en, vt[i].exp_en);
            chk($sformatf("v%0d_wr_addr", i), bus.wr_addr, vt[i].exp_addr);
            chk($sformatf("v%0d_wr_data", i), bus.wr_data, vt[i].exp_data);
        end
        chk("rf_r0_zero", rf[0], 0);
        chk("rf_r9_last_wins", rf[9], D2);

        // Reset lands while req0 is being granted; ptr is 1 at this point.
        bus.hold      = 1'b0;
        bus.req_valid = 3'b001;
        bus.req_rd    = RD_A;
        bus.req_data  = DA;
        #1;
        chk("t5_pre_ready", bus.req_ready, 3'b001);
        rst = 1'b0;
        #1;
        chk("t5_rst_wr_en", bus.wr_en, 0);
        chk("t5_rst_wr_addr", bus.wr_addr, 0);
        chk("t5_rst_wr_data", bus.wr_data, 0);
        chk("t5_rst_busy", bus.init_busy, 1);
        chk("t5_rst_ready", bus.req_ready, 0);
        bus.req_valid = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_clear(3'b001);

        pend     = '0;
        acc      = '0;
        rrd      = '0;
        rdat     = '0;
        have_exp = 1'b0;
        exp_en   = 1'b0;
        exp_a    = '0;
        exp_d    = '0;
        for (int i = 0; i < 3; i++) wt[i] = 0;

        for (int c = 0; c < 3000; c++) begin
            if (have_exp) begin
                chk("rnd_wr_en", bus.wr_en, exp_en);
                if (exp_en) begin
                    chk("rnd_wr_addr", bus.wr_addr, exp_a);
                    chk("rnd_wr_data", bus.wr_data, exp_d);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    rrd[i*5 +: 5]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    rdat[i*32 +: 32] = $urandom;
                    wt[i] = 0;
                end
            end
            bus.hold      = ($urandom_range(0, 4) == 0);
            bus.req_valid = pend;
            bus.req_rd    = rrd;
            bus.req_data  = rdat;
            @(negedge clk);
            r = bus.req_ready;
            chk("rnd_onehot0", $onehot0(r), 1);
            chk("rnd_ready_subset", r & ~pend, 0);
            if (bus.hold) chk("rnd_hold_no_grant", r, 0);
            else if (pend != 3'b000) chk("rnd_grant_when_valid", (r != 3'b000), 1);
            acc    = r & pend;
            exp_en = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    chk($sformatf("rnd_wait_bound_%0d", i), (wt[i] <= NREQ - 1), 1);
                    exp_en = (rrd[i*5 +: 5] != 5'd0);
                    exp_a  = rrd[i*5 +: 5];
                    exp_d  = rdat[i*32 +: 32];
                end else if (pend[i] && !bus.hold) begin
                    wt[i]++;
                end
            end
            have_exp = 1'b1;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rnd_final_wait_%0d", i), (wt[i] <= NREQ - 1), 1);
        end
        chk("rnd_rf_r0_zero", rf[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
